// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between the IF (read-only) and MEM (read/write) requesters.
// Define RR_ARB_EN for a round-robin tie-break; otherwise DM wins simultaneous requests.
module mem_port_arbiter #(
  parameter int LAT = 2,
  parameter int CW  = 4,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic          grant;      // 1 = DM owns the port
  logic          start;
  logic          finish;
  logic          pick_dm;

`ifdef RR_ARB_EN
  logic          last_grant; // 1 = DM was granted last
`endif

  assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    pick_dm   = dm_req;
`ifdef RR_ARB_EN
    if (if_req && dm_req) pick_dm = ~last_grant;
`endif
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          start     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (count == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      grant     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      if_ready <= finish & ~grant;
      dm_ready <= finish & grant;
      if (start) begin
        grant     <= pick_dm;
        count     <= CW'(LAT - 1);
        mem_en    <= 1'b1;
        mem_we    <= pick_dm & dm_we;
        mem_addr  <= pick_dm ? dm_addr : if_addr;
        mem_wdata <= pick_dm ? dm_wdata : '0;
      end else if (state == ACCESS) begin
        if (count != '0) begin
          count <= count - CW'(1);
        end else begin
          // Last access cycle: memory data is valid now, port is released.
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (grant) dm_rdata <= mem_rdata;
          else       if_rdata <= mem_rdata;
        end
      end
    end
  end

`ifdef RR_ARB_EN
  always_ff @(posedge clk) begin
    if (rst)        last_grant <= 1'b0;
    else if (start) last_grant <= pick_dm;
  end
`endif

endmodule
